mac_relu_sequencer: RTL

// Command-driven issuer for the accelerator ALU: the controller end of the ALUCtl/in1/in2 -> out/out2 interface.

---
 rtl/accel_pkg.sv | 23 ++
 rtl/mac_relu_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/accel_pkg.sv
// Shared header for the accelerator issuer: ALU opcodes, command encodings and sequencer states.
package accel_pkg;

    localparam logic [4:0] ALU_ADD  = 5'b00010;
    localparam logic [4:0] ALU_MAC  = 5'b11100;
    localparam logic [4:0] ALU_RELU = 5'b11101;
    localparam logic [4:0] ALU_NOP  = 5'b11111;

    localparam logic OP_DOT  = 1'b0;
    localparam logic OP_RELU = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_EXEC,
        ST_ACC,
        ST_WR,
        ST_WR2,
        ST_DONE
    } state_t;

endpackage

// File: rtl/mac_relu_sequencer.sv
// Command-driven issuer for the shared ALU: streams operands from a 1-cycle RAM, runs a MAC dot product
// or element-wise ReLU, and writes results back.
//
// state   | meaning
// IDLE    | waiting for a command, cmd_ready high
// RD_A    | read a[i]
// RD_B    | latch a[i]; read b[i] (DOT) or a[i+1] (RELU, if present)
// EXEC    | ALU MAC / RELU on the operand pair
// ACC     | ALU ADD folds the product into the accumulator (DOT)
// WR      | DOT: write acc to dst; RELU: write r0 to dst+i
// WR2     | RELU: write r1 to dst+i+1
// DONE    | one-cycle completion pulse
module mac_relu_sequencer
    import accel_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [31:0]       mem_rd_data,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [31:0]       mem_wr_data,
    output logic [4:0]        alu_ctl,
    output logic [31:0]       alu_in1,
    output logic [31:0]       alu_in2,
    output logic              alu_sign,
    input  logic [31:0]       alu_out,
    input  logic [31:0]       alu_out2,
    output logic              busy,
    output logic              done
);

    localparam logic [LEN_W:0] IDX_ONE = (LEN_W + 1)'(1);
    localparam logic [LEN_W:0] IDX_TWO = (LEN_W + 1)'(2);

    state_t              r_state;
    logic                r_op;
    logic [ADDR_W-1:0]   r_src_a;
    logic [ADDR_W-1:0]   r_src_b;
    logic [ADDR_W-1:0]   r_dst;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W:0]      r_idx;
    logic [31:0]         r_acc;
    logic [31:0]         r_opa;
    logic [31:0]         r_prod;
    logic [31:0]         r_r0;
    logic [31:0]         r_r1;

    logic [LEN_W:0]      w_idx_p1;
    logic [LEN_W:0]      w_idx_p2;
    logic                w_more1;
    logic                w_more2;
    logic [ADDR_W-1:0]   w_a_addr;
    logic [ADDR_W-1:0]   w_a_addr_p1;
    logic [ADDR_W-1:0]   w_b_addr;
    logic [ADDR_W-1:0]   w_dst_i;
    logic [ADDR_W-1:0]   w_dst_i1;

    // Index carries one extra bit so i+2 cannot overflow on the last RELU pair.
    assign w_idx_p1    = r_idx + IDX_ONE;
    assign w_idx_p2    = r_idx + IDX_TWO;
    assign w_more1     = w_idx_p1 < {1'b0, r_len};
    assign w_more2     = w_idx_p2 < {1'b0, r_len};
    assign w_a_addr    = r_src_a + ADDR_W'(r_idx);
    assign w_a_addr_p1 = r_src_a + ADDR_W'(w_idx_p1);
    assign w_b_addr    = r_src_b + ADDR_W'(r_idx);
    assign w_dst_i     = r_dst + ADDR_W'(r_idx);
    assign w_dst_i1    = r_dst + ADDR_W'(w_idx_p1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_op    <= OP_DOT;
            r_src_a <= '0;
            r_src_b <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_opa   <= '0;
            r_prod  <= '0;
            r_r0    <= '0;
            r_r1    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_src_a <= cmd_src_a;
                        r_src_b <= cmd_src_b;
                        r_dst   <= cmd_dst;
                        r_len   <= cmd_len;
                        r_idx   <= '0;
                        r_acc   <= '0;
                        if (cmd_len != '0)
                            r_state <= ST_RD_A;
                        else
                            r_state <= (cmd_op == OP_DOT) ? ST_WR : ST_DONE;
                    end
                end
                ST_RD_A: r_state <= ST_RD_B;
                ST_RD_B: begin
                    r_opa   <= mem_rd_data;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_op == OP_DOT) begin
                        r_prod  <= alu_out;
                        r_state <= ST_ACC;
                    end else begin
                        r_r0    <= alu_out;
                        r_r1    <= alu_out2;
                        r_state <= ST_WR;
                    end
                end
                ST_ACC: begin
                    r_acc <= alu_out;
                    if (w_more1) begin
                        r_idx   <= w_idx_p1;
                        r_state <= ST_RD_A;
                    end else begin
                        r_state <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (r_op == OP_RELU && w_more1)
                        r_state <= ST_WR2;
                    else
                        r_state <= ST_DONE;
                end
                ST_WR2: begin
                    r_idx   <= w_idx_p2;
                    r_state <= w_more2 ? ST_RD_A : ST_DONE;
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign alu_sign  = 1'b0;

    always_comb begin
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        mem_wr_en   = 1'b0;
        mem_wr_addr = '0;
        mem_wr_data = '0;
        alu_ctl     = ALU_NOP;
        alu_in1     = '0;
        alu_in2     = '0;
        done        = 1'b0;
        case (r_state)
            ST_RD_A: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = w_a_addr;
            end
            ST_RD_B: begin
                if (r_op == OP_DOT) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = w_b_addr;
                end else if (w_more1) begin
                    mem_rd_en   = 1'b1;
                    mem_rd_addr = w_a_addr_p1;
                end
            end
            ST_EXEC: begin
                alu_ctl = (r_op == OP_DOT) ? ALU_MAC : ALU_RELU;
                alu_in1 = r_opa;
                // A RELU tail element has no partner; feed zero so out2 is harmless.
                alu_in2 = (r_op == OP_DOT || w_more1) ? mem_rd_data : 32'h0;
            end
            ST_ACC: begin
                alu_ctl = ALU_ADD;
                alu_in1 = r_acc;
                alu_in2 = r_prod;
            end
            ST_WR: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = (r_op == OP_DOT) ? r_dst : w_dst_i;
                mem_wr_data = (r_op == OP_DOT) ? r_acc : r_r0;
            end
            ST_WR2: begin
                mem_wr_en   = 1'b1;
                mem_wr_addr = w_dst_i1;
                mem_wr_data = r_r1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule
